// File: rtl/miller_pkg.sv
// Shared types and constants for the Miller bit-to-frame receiver.
package miller_pkg;

   typedef enum logic [1:0] {
      StHunt,
      StLen,
      StData,
      StCrc
   } state_e;

   typedef enum logic [1:0] {
      ErrNone    = 2'd0,
      ErrLen     = 2'd1,
      ErrCrc     = 2'd2,
      ErrTimeout = 2'd3
   } rx_err_e;

   localparam logic [15:0] CrcPoly         = 16'h1021;
   localparam logic [15:0] CrcInit         = 16'hFFFF;
   localparam logic [15:0] DefaultSyncWord = 16'hEB90;

endpackage

// File: rtl/miller_frame_rx_if.sv
// Bit stream from the demodulator in, byte stream and frame status out.
interface miller_frame_rx_if;

   logic       bit_in;
   logic       bit_in_valid;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_sop;
   logic       frame_done;
   logic       frame_ok;
   logic [1:0] rx_err;
   logic       busy;

   // Driver of bits and consumer of bytes.
   modport master (
      output bit_in, bit_in_valid,
      input  rx_data, rx_valid, rx_sop, frame_done, frame_ok, rx_err, busy
   );

   // The receiver itself.
   modport slave (
      input  bit_in, bit_in_valid,
      output rx_data, rx_valid, rx_sop, frame_done, frame_ok, rx_err, busy
   );

endinterface

// File: rtl/crc16_ccitt_serial.sv
// Bit-serial CRC-16/CCITT-FALSE, one message bit per enable.
module crc16_ccitt_serial
   import miller_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        init,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         crc <= 16'h0000;
      end else if (init) begin
         crc <= CrcInit;
      end else if (en) begin
         crc <= {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CrcPoly : 16'h0000);
      end
   end

endmodule

// File: rtl/miller_frame_rx.sv
// Frame receiver: sync hunt, length byte, MSB-first payload bytes, CRC-16 trailer check.
module miller_frame_rx
   import miller_pkg::*;
#(
   parameter logic [15:0] SYNC_WORD   = DefaultSyncWord,
   parameter int unsigned MAX_LEN     = 64,
   parameter int unsigned BIT_TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   miller_frame_rx_if.slave    bus
);

   localparam int unsigned IdleW = $clog2(BIT_TIMEOUT + 1);

   state_e           state;
   logic [15:0]      hist;
   logic [4:0]       fill;
   logic [15:0]      shreg;
   logic [3:0]       bit_cnt;
   logic [7:0]       byte_cnt;
   logic [IdleW-1:0] idle;
   logic             first;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_sop;
   logic       frame_done;
   logic       frame_ok;
   logic [1:0] rx_err;
   logic       busy;

   logic        strobe;
   logic        timeout;
   logic [15:0] hist_next;
   logic [15:0] sh_next;
   logic [15:0] crc;

   assign strobe    = bus.bit_in_valid;
   assign hist_next = {hist[14:0], bus.bit_in};
   assign sh_next   = {shreg[14:0], bus.bit_in};
   // Fires on the edge where the idle count would reach BIT_TIMEOUT; beats a same-cycle strobe.
   assign timeout   = (state != StHunt) && (idle >= IdleW'(BIT_TIMEOUT - 1));

   crc16_ccitt_serial u_crc (
      .clk   (clk),
      .rst_n (rst_n),
      .init  (state == StLen),
      .en    ((state == StData) && strobe && !timeout),
      .din   (bus.bit_in),
      .crc   (crc)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= StHunt;
         hist       <= '0;
         fill       <= '0;
         shreg      <= '0;
         bit_cnt    <= '0;
         byte_cnt   <= '0;
         idle       <= '0;
         first      <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         rx_sop     <= 1'b0;
         frame_done <= 1'b0;
         frame_ok   <= 1'b0;
         rx_err     <= ErrNone;
         busy       <= 1'b0;
      end else begin
         rx_valid   <= 1'b0;
         rx_sop     <= 1'b0;
         frame_done <= 1'b0;
         // History is kept clear outside HUNT so every entry to HUNT starts from an empty fill.
         if (state != StHunt) begin
            hist <= '0;
            fill <= '0;
         end
         if (state == StHunt) begin
            idle <= '0;
         end else if (strobe) begin
            idle <= '0;
         end else if (idle != IdleW'(BIT_TIMEOUT)) begin
            idle <= idle + 1'b1;
         end

         if (timeout) begin
            frame_done <= 1'b1;
            frame_ok   <= 1'b0;
            rx_err     <= ErrTimeout;
            busy       <= 1'b0;
            bit_cnt    <= '0;
            state      <= StHunt;
         end else if (strobe) begin
            unique case (state)
               StHunt: begin
                  hist <= hist_next;
                  if (fill < 5'd16) fill <= fill + 1'b1;
                  if (fill >= 5'd15 && hist_next == SYNC_WORD) begin
                     bit_cnt <= '0;
                     busy    <= 1'b1;
                     state   <= StLen;
                  end
               end
               StLen: begin
                  shreg   <= sh_next;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 4'd7) begin
                     bit_cnt <= '0;
                     if (sh_next[7:0] == 8'd0 || sh_next[7:0] > 8'(MAX_LEN)) begin
                        frame_done <= 1'b1;
                        frame_ok   <= 1'b0;
                        rx_err     <= ErrLen;
                        busy       <= 1'b0;
                        state      <= StHunt;
                     end else begin
                        byte_cnt <= sh_next[7:0];
                        first    <= 1'b1;
                        state    <= StData;
                     end
                  end
               end
               StData: begin
                  shreg   <= sh_next;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 4'd7) begin
                     bit_cnt  <= '0;
                     rx_data  <= sh_next[7:0];
                     rx_valid <= 1'b1;
                     rx_sop   <= first;
                     first    <= 1'b0;
                     byte_cnt <= byte_cnt - 1'b1;
                     if (byte_cnt == 8'd1) state <= StCrc;
                  end
               end
               StCrc: begin
                  shreg   <= sh_next;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 4'd15) begin
                     bit_cnt    <= '0;
                     frame_done <= 1'b1;
                     frame_ok   <= (sh_next == crc);
                     rx_err     <= (sh_next == crc) ? ErrNone : ErrCrc;
                     busy       <= 1'b0;
                     state      <= StHunt;
                  end
               end
               default: state <= StHunt;
            endcase
         end
      end
   end

   assign bus.rx_data    = rx_data;
   assign bus.rx_valid   = rx_valid;
   assign bus.rx_sop     = rx_sop;
   assign bus.frame_done = frame_done;
   assign bus.frame_ok   = frame_ok;
   assign bus.rx_err     = rx_err;
   assign bus.busy       = busy;

endmodule

// File: tb/tb_miller_frame_rx.sv
// Scoreboard bench for miller_frame_rx: directed frames queue expected bytes/status, monitor checks.
module tb_miller_frame_rx;

   localparam logic [15:0] Sync       = 16'hEB90;
   localparam int          BitTimeout = 64;

   typedef struct packed {
      logic       is_done;
      logic [7:0] data;
      logic       sop;
      logic       ok;
      logic [1:0] err;
      logic       chk_to;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   last_strobe_cyc;
   int   checks;
   int   errors;
   exp_t q[$];
   logic [7:0] pl [0:15];

   miller_frame_rx_if bus ();

   miller_frame_rx #(
      .SYNC_WORD   (Sync),
      .MAX_LEN     (64),
      .BIT_TIMEOUT (BitTimeout)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] d, input logic s);
      q.push_back({1'b0, d, s, 1'b0, 2'd0, 1'b0});
   endtask

   task automatic push_done(input logic ok, input logic [1:0] err, input logic chk_to);
      q.push_back({1'b1, 8'h00, 1'b0, ok, err, chk_to});
   endtask

   task automatic send_bit(input logic b, input int gap);
      bus.bit_in       = b;
      bus.bit_in_valid = 1'b1;
      @(posedge clk);
      #1;
      last_strobe_cyc  = cyc;
      bus.bit_in_valid = 1'b0;
      repeat (gap - 1) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bits(input logic [15:0] v, input int n, input int gap);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i], gap);
   endtask

   function automatic logic [15:0] tb_crc(input int n);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         for (int b = 7; b >= 0; b--) begin
            c = {c[14:0], 1'b0} ^ ((c[15] ^ pl[i][b]) ? 16'h1021 : 16'h0000);
         end
      end
      return c;
   endfunction

   task automatic load_digits();
      for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
   endtask

   task automatic send_frame(input int n, input int gap, input logic [15:0] trailer,
                             input logic ok, input logic [1:0] err);
      for (int i = 0; i < n; i++) push_byte(pl[i], i == 0);
      push_done(ok, err, 1'b0);
      send_bits(Sync, 16, gap);
      check("busy_after_sync", {31'd0, bus.busy}, 1);
      send_bits(16'(n), 8, gap);
      for (int i = 0; i < n; i++) send_bits({8'h00, pl[i]}, 8, gap);
      send_bits(trailer, 16, gap);
   endtask

   task automatic idle_clocks(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: every presented byte or frame status is matched against the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.rx_valid) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %h expected none", bus.rx_data);
         end else begin
            e = q.pop_front();
            check("rx_byte", {22'd0, 1'b0, bus.rx_sop, bus.rx_data},
                  {22'd0, e.is_done, e.sop, e.data});
            check("busy_during_byte", {31'd0, bus.busy}, 1);
         end
      end
      if (rst_n && bus.frame_done) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got ok=%b err=%0d expected none",
                     bus.frame_ok, bus.rx_err);
         end else begin
            e = q.pop_front();
            check("frame_status", {28'd0, 1'b1, bus.frame_ok, bus.rx_err},
                  {28'd0, e.is_done, e.ok, e.err});
            check("busy_at_done", {31'd0, bus.busy}, 0);
            if (e.chk_to) check("timeout_latency", cyc - last_strobe_cyc, BitTimeout);
         end
      end
   end

   initial begin
      checks           = 0;
      errors           = 0;
      last_strobe_cyc  = 0;
      rst_n            = 1'b0;
      bus.bit_in       = 1'b0;
      bus.bit_in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {18'd0, bus.rx_data, bus.rx_valid, bus.rx_sop, bus.frame_done,
                              bus.frame_ok, bus.rx_err, bus.busy}, 0);
      rst_n = 1'b1;
      idle_clocks(4);

      // Good frame, then the same frame with a corrupted trailer.
      load_digits();
      send_frame(9, 16, 16'h29B1, 1'b1, 2'd0);
      idle_clocks(10);
      send_frame(9, 16, 16'h29B0, 1'b0, 2'd2);
      idle_clocks(10);

      // Bad lengths, then a normal frame.
      push_done(1'b0, 2'd1, 1'b0);
      send_bits(Sync, 16, 16);
      send_bits(16'h0000, 8, 16);
      idle_clocks(10);
      push_done(1'b0, 2'd1, 1'b0);
      send_bits(Sync, 16, 16);
      send_bits(16'h0041, 8, 16);
      idle_clocks(10);
      send_frame(9, 16, 16'h29B1, 1'b1, 2'd0);
      idle_clocks(10);

      // Near-miss sync patterns must not lock.
      send_bits(16'h0000, 8, 16);
      send_bits(16'hEB8F, 16, 16);
      send_bits(16'h75C8, 16, 16);
      for (int i = 0; i < 5; i++) pl[i] = 8'h41 + 8'(i);
      send_frame(5, 16, tb_crc(5), 1'b1, 2'd0);
      idle_clocks(10);

      // Timeout after three payload bytes.
      load_digits();
      for (int i = 0; i < 3; i++) push_byte(pl[i], i == 0);
      push_done(1'b0, 2'd3, 1'b1);
      send_bits(Sync, 16, 16);
      send_bits(16'h0009, 8, 16);
      for (int i = 0; i < 3; i++) send_bits({8'h00, pl[i]}, 8, 16);
      idle_clocks(80);

      // Timeout again, with a strobe landing on the timeout edge.
      for (int i = 0; i < 3; i++) push_byte(pl[i], i == 0);
      push_done(1'b0, 2'd3, 1'b1);
      send_bits(Sync, 16, 16);
      send_bits(16'h0009, 8, 16);
      for (int i = 0; i < 3; i++) send_bits({8'h00, pl[i]}, 8, 16);
      idle_clocks(BitTimeout - 1 - (cyc - last_strobe_cyc));
      bus.bit_in       = 1'b1;
      bus.bit_in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.bit_in_valid = 1'b0;
      idle_clocks(10);
      check("busy_after_timeout", {31'd0, bus.busy}, 0);
      send_frame(9, 16, 16'h29B1, 1'b1, 2'd0);
      idle_clocks(10);

      // Back-to-back frames at one strobe per clock.
      send_frame(9, 1, 16'h29B1, 1'b1, 2'd0);
      send_frame(9, 1, 16'h29B1, 1'b1, 2'd0);
      idle_clocks(10);

      // Reset mid-payload drops the frame silently.
      push_byte(pl[0], 1'b1);
      push_byte(pl[1], 1'b0);
      send_bits(Sync, 16, 16);
      send_bits(16'h0009, 8, 16);
      send_bits({8'h00, pl[0]}, 8, 16);
      send_bits({8'h00, pl[1]}, 8, 16);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midframe_reset_outputs", {18'd0, bus.rx_data, bus.rx_valid, bus.rx_sop,
                                       bus.frame_done, bus.frame_ok, bus.rx_err, bus.busy}, 0);
      rst_n = 1'b1;
      idle_clocks(4);
      send_frame(9, 16, 16'h29B1, 1'b1, 2'd0);
      idle_clocks(20);

      check("scoreboard_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
